// File: rtl/pratica_6_pkg.sv
// Shared types and widths for the pratica_6 input-sequence stage.
package pratica_6_pkg;

   localparam int unsigned CODE_W = 4;

   typedef enum logic [1:0] {D_IDLE, D_PRESS, D_HELD, D_REL} deb_state_t;

endpackage

// File: rtl/pratica_6_input_seq_if.sv
// Board-side signal bundle: button/mode inputs and the M1..M4 pattern with step/wrap flags.
interface pratica_6_input_seq_if;

   logic btn_step;
   logic run;
   logic M1;
   logic M2;
   logic M3;
   logic M4;
   logic step;
   logic wrap;

   modport slave (
      input  btn_step, run,
      output M1, M2, M3, M4, step, wrap
   );

   modport master (
      output btn_step, run,
      input  M1, M2, M3, M4, step, wrap
   );

endinterface

// File: rtl/debounce_btn.sv
// Two-flop synchronizer plus press/release debounce FSM; one press_evt per accepted press.
module debounce_btn
   import pratica_6_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic press_evt
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic             btn_s;
   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign sync_d = {sync_q[0], btn_in};
   assign btn_s  = sync_q[1];

   // press_evt is decoded from registered state so the counter registers it on the acceptance edge
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_evt = 1'b0;
      unique case (state_q)
         D_IDLE: begin
            if (btn_s) begin
               state_d = D_PRESS;
               cnt_d   = '0;
            end
         end
         D_PRESS: begin
            if (!btn_s) begin
               state_d = D_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = D_HELD;
               press_evt = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         D_HELD: begin
            if (!btn_s) begin
               state_d = D_REL;
               cnt_d   = '0;
            end
         end
         D_REL: begin
            if (btn_s) begin
               state_d = D_HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = D_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = D_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         state_q <= D_IDLE;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/pratica_6_input_seq.sv
// Steps a 4-bit pattern M1..M4 through 0000..1111 from a debounced button or a prescaled tick.
module pratica_6_input_seq
   import pratica_6_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50_000,
   parameter int unsigned AUTO_DIV        = 50_000_000
) (
   input logic                  clk,
   input logic                  rst,
   pratica_6_input_seq_if.slave io
);

   localparam int unsigned PRE_W = $clog2(AUTO_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

   logic              press_evt;
   logic              tick;
   logic              step_req;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              step_q, step_d;
   logic              wrap_q, wrap_d;

   debounce_btn #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (io.btn_step),
      .press_evt(press_evt)
   );

   // Prescaler is held clear in manual mode so no partial tick survives a mode change
   assign tick     = io.run && (presc_q == PRE_LAST);
   assign step_req = io.run ? tick : press_evt;

   always_comb begin
      presc_d = presc_q;
      if (!io.run || tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_comb begin
      code_d = code_q;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (step_req) begin
         code_d = code_q + 1'b1;
         step_d = 1'b1;
         wrap_d = (code_q == '1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         code_q  <= '0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         code_q  <= code_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
      end
   end

   assign {io.M1, io.M2, io.M3, io.M4} = code_q;
   assign io.step = step_q;
   assign io.wrap = wrap_q;

endmodule

// File: tb/tb_pratica_6_input_seq.sv
// Directed bench for pratica_6_input_seq with DEBOUNCE_CYCLES=4, AUTO_DIV=8.
module tb_pratica_6_input_seq;

   logic       clk;
   logic       rst;
   logic [3:0] pat;
   int         vectors;
   int         miscompares;
   logic [3:0] exp_code;

   pratica_6_input_seq_if bus ();

   pratica_6_input_seq #(
      .DEBOUNCE_CYCLES(4),
      .AUTO_DIV       (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io (bus.slave)
   );

   assign pat = {bus.M1, bus.M2, bus.M3, bus.M4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; all driving and sampling happens there
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_code = 4'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.btn_step = 1'b1;
      bus.run = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         vectors++;
         if (pat !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_pattern cyc%0d: got %b want 0000", k, pat);
         end
         vectors++;
         if (bus.step !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_step cyc%0d: got %b want 0", k, bus.step);
         end
         vectors++;
         if (bus.wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wrap cyc%0d: got %b want 0", k, bus.wrap);
         end
      end
      rst = 1'b0;
      bus.btn_step = 1'b0;
      bus.run = 1'b0;
      exp_code = 4'h0;
      for (int k = 0; k < 4; k++) cyc();
      vectors++;
      if (pat !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_idle_pattern: got %b want 0000", pat);
      end
   endtask

   // Hold the button for hold cycles in manual mode; one step expected 7 edges after the press
   task automatic press_manual(input string name, input int hold, input int rel);
      bus.btn_step = 1'b1;
      for (int k = 1; k <= hold; k++) begin
         cyc();
         if (k == 7) exp_code = exp_code + 4'h1;
         vectors++;
         if (bus.step !== (k == 7)) begin
            miscompares++;
            $display("FAIL %s_step k=%0d: got %b want %b", name, k, bus.step, (k == 7));
         end
         vectors++;
         if (pat !== exp_code) begin
            miscompares++;
            $display("FAIL %s_pattern k=%0d: got %b want %b", name, k, pat, exp_code);
         end
      end
      bus.btn_step = 1'b0;
      for (int k = 1; k <= rel; k++) begin
         cyc();
         vectors++;
         if (bus.step !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_release_step k=%0d: got %b want 0", name, k, bus.step);
         end
      end
   endtask

   task automatic test_clean_press();
      bus.run = 1'b0;
      press_manual("press1", 20, 12);
      vectors++;
      if (pat !== 4'b0001) begin
         miscompares++;
         $display("FAIL press1_final: got %b want 0001", pat);
      end
      press_manual("press2", 20, 12);
      vectors++;
      if (pat !== 4'b0010) begin
         miscompares++;
         $display("FAIL press2_final: got %b want 0010", pat);
      end
   endtask

   task automatic test_bounce();
      int steps;
      steps = 0;
      bus.run = 1'b0;
      for (int k = 0; k < 22; k++) begin
         bus.btn_step = (k < 12) ? ~k[1] : 1'b0;
         cyc();
         if (bus.step === 1'b1) steps++;
      end
      vectors++;
      if (steps != 0) begin
         miscompares++;
         $display("FAIL bounce_steps: got %0d want 0", steps);
      end
      vectors++;
      if (pat !== exp_code) begin
         miscompares++;
         $display("FAIL bounce_pattern: got %b want %b", pat, exp_code);
      end
   endtask

   task automatic test_auto_sweep();
      logic exp_step;
      logic exp_wrap;
      do_reset();
      bus.run = 1'b1;
      for (int k = 1; k <= 128; k++) begin
         cyc();
         exp_step = (k % 8 == 0);
         if (exp_step) exp_code = exp_code + 4'h1;
         exp_wrap = exp_step && (exp_code == 4'h0);
         vectors++;
         if (bus.step !== exp_step) begin
            miscompares++;
            $display("FAIL sweep_step k=%0d: got %b want %b", k, bus.step, exp_step);
         end
         vectors++;
         if (bus.wrap !== exp_wrap) begin
            miscompares++;
            $display("FAIL sweep_wrap k=%0d: got %b want %b", k, bus.wrap, exp_wrap);
         end
         vectors++;
         if (pat !== exp_code) begin
            miscompares++;
            $display("FAIL sweep_pattern k=%0d: got %b want %b", k, pat, exp_code);
         end
      end
      bus.run = 1'b0;
      cyc();
   endtask

   task automatic test_mode_mix();
      logic exp_step;
      bus.run = 1'b1;
      bus.btn_step = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         exp_step = (k % 8 == 0);
         if (exp_step) exp_code = exp_code + 4'h1;
         vectors++;
         if (bus.step !== exp_step) begin
            miscompares++;
            $display("FAIL mix_auto_step k=%0d: got %b want %b", k, bus.step, exp_step);
         end
      end
      vectors++;
      if (pat !== exp_code) begin
         miscompares++;
         $display("FAIL mix_auto_pattern: got %b want %b", pat, exp_code);
      end
      bus.run = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         vectors++;
         if (bus.step !== 1'b0) begin
            miscompares++;
            $display("FAIL mix_held_step k=%0d: got %b want 0", k, bus.step);
         end
      end
      bus.btn_step = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         vectors++;
         if (bus.step !== 1'b0) begin
            miscompares++;
            $display("FAIL mix_release_step k=%0d: got %b want 0", k, bus.step);
         end
      end
      press_manual("mix_repress", 10, 10);
      vectors++;
      if (pat !== exp_code) begin
         miscompares++;
         $display("FAIL mix_final_pattern: got %b want %b", pat, exp_code);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      bus.run = 1'b1;
      for (int k = 1; k <= 83; k++) cyc();
      vectors++;
      if (pat !== 4'b1010) begin
         miscompares++;
         $display("FAIL midrst_pre_pattern: got %b want 1010", pat);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      vectors++;
      if (pat !== 4'h0) begin
         miscompares++;
         $display("FAIL midrst_pattern: got %b want 0000", pat);
      end
      vectors++;
      if (bus.step !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_step: got %b want 0", bus.step);
      end
      for (int k = 1; k <= 8; k++) begin
         cyc();
         vectors++;
         if (bus.step !== (k == 8)) begin
            miscompares++;
            $display("FAIL midrst_restart_step k=%0d: got %b want %b", k, bus.step, (k == 8));
         end
         vectors++;
         if (pat !== ((k == 8) ? 4'b0001 : 4'b0000)) begin
            miscompares++;
            $display("FAIL midrst_restart_pattern k=%0d: got %b want %b", k, pat,
                     ((k == 8) ? 4'b0001 : 4'b0000));
         end
      end
      bus.run = 1'b0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      exp_code = 4'h0;
      rst = 1'b1;
      bus.btn_step = 1'b0;
      bus.run = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_sweep();
      test_mode_mix();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
